// File: rtl/smart_parking_system.sv
// Parking-lot controller: counts occupied slots and drives timed entry/exit barriers
// from edge-detected car-presence sensors.
module smart_parking_system #(
  parameter int CAPACITY         = 2,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic [4:0] available_spaces,
  output logic       parking_full,
  output logic       parking_empty
);

  localparam logic [4:0] CAP_C  = 5'(CAPACITY);
  localparam logic [7:0] OPEN_C = 8'(GATE_OPEN_CYCLES);

  typedef enum logic {
    GATE_CLOSED = 1'b0,
    GATE_OPEN   = 1'b1
  } gate_state_e;

  gate_state_e entry_state_r;
  gate_state_e exit_state_r;
  logic [7:0]  entry_timer_r;
  logic [7:0]  exit_timer_r;
  logic        entry_prev_r;
  logic        exit_prev_r;
  logic [4:0]  occupied_r;
  logic        entry_accept_s;
  logic        exit_accept_s;

  // Accept a request on a fresh sensor edge only when the gate is idle and the lot allows it.
  always_comb begin
    entry_accept_s = 1'b0;
    exit_accept_s  = 1'b0;
    if (entry_sensor && !entry_prev_r && (entry_state_r == GATE_CLOSED) && (occupied_r < CAP_C)) begin
      entry_accept_s = 1'b1;
    end else begin
      entry_accept_s = 1'b0;
    end
    if (exit_sensor && !exit_prev_r && (exit_state_r == GATE_CLOSED) && (occupied_r != 5'd0)) begin
      exit_accept_s = 1'b1;
    end else begin
      exit_accept_s = 1'b0;
    end
  end

  // Sensor history for edge detection; a held-high sensor yields a single request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_prev_r <= 1'b0;
      exit_prev_r  <= 1'b0;
    end else begin
      entry_prev_r <= entry_sensor;
      exit_prev_r  <= exit_sensor;
    end
  end

  // Occupancy counter; a simultaneous accepted entry and exit cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied_r <= 5'd0;
    end else begin
      case ({entry_accept_s, exit_accept_s})
        2'b10:   occupied_r <= occupied_r + 5'd1;
        2'b01:   occupied_r <= occupied_r - 5'd1;
        default: occupied_r <= occupied_r;
      endcase
    end
  end

  // Entry barrier FSM: stays open for OPEN_C cycles after an accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_state_r <= GATE_CLOSED;
      entry_timer_r <= 8'd0;
      entry_gate    <= 1'b0;
    end else begin
      case (entry_state_r)
        GATE_CLOSED: begin
          if (entry_accept_s) begin
            entry_state_r <= GATE_OPEN;
            entry_timer_r <= OPEN_C;
            entry_gate    <= 1'b1;
          end else begin
            entry_timer_r <= 8'd0;
            entry_gate    <= 1'b0;
          end
        end
        GATE_OPEN: begin
          if (entry_timer_r <= 8'd1) begin
            entry_state_r <= GATE_CLOSED;
            entry_timer_r <= 8'd0;
            entry_gate    <= 1'b0;
          end else begin
            entry_timer_r <= entry_timer_r - 8'd1;
            entry_gate    <= 1'b1;
          end
        end
        default: begin
          entry_state_r <= GATE_CLOSED;
          entry_timer_r <= 8'd0;
          entry_gate    <= 1'b0;
        end
      endcase
    end
  end

  // Exit barrier FSM, mirror of the entry side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exit_state_r <= GATE_CLOSED;
      exit_timer_r <= 8'd0;
      exit_gate    <= 1'b0;
    end else begin
      case (exit_state_r)
        GATE_CLOSED: begin
          if (exit_accept_s) begin
            exit_state_r <= GATE_OPEN;
            exit_timer_r <= OPEN_C;
            exit_gate    <= 1'b1;
          end else begin
            exit_timer_r <= 8'd0;
            exit_gate    <= 1'b0;
          end
        end
        GATE_OPEN: begin
          if (exit_timer_r <= 8'd1) begin
            exit_state_r <= GATE_CLOSED;
            exit_timer_r <= 8'd0;
            exit_gate    <= 1'b0;
          end else begin
            exit_timer_r <= exit_timer_r - 8'd1;
            exit_gate    <= 1'b1;
          end
        end
        default: begin
          exit_state_r <= GATE_CLOSED;
          exit_timer_r <= 8'd0;
          exit_gate    <= 1'b0;
        end
      endcase
    end
  end

  assign available_spaces = CAP_C - occupied_r;
  assign parking_full     = (occupied_r == CAP_C);
  assign parking_empty    = (occupied_r == 5'd0);

endmodule

// File: tb/tb_smart_parking_system.sv
// Scoreboard bench for smart_parking_system (CAPACITY=2, 8-cycle gates, 20 ns clock).
module tb_smart_parking_system;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic       entry_gate;
  logic       exit_gate;
  logic [4:0] available_spaces;
  logic       parking_full;
  logic       parking_empty;

  typedef struct {
    logic       eg;
    logic       xg;
    logic [4:0] av;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  smart_parking_system #(.CAPACITY(2), .GATE_OPEN_CYCLES(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .entry_sensor     (entry_sensor),
    .exit_sensor      (exit_sensor),
    .entry_gate       (entry_gate),
    .exit_gate        (exit_gate),
    .available_spaces (available_spaces),
    .parking_full     (parking_full),
    .parking_empty    (parking_empty)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Drive one row for rep cycles; expected values describe the state after each edge.
  task automatic run(input bit rst, input bit en, input bit ex, input int rep,
                     input bit eg, input bit xg, input logic [4:0] av);
    exp_t e;
    for (int i = 0; i < rep; i++) begin
      @(posedge clk);
      #2;
      entry_sensor = en;
      exit_sensor  = ex;
      if (rst) begin
        reset = 1'b1;
        #3;
        reset = 1'b0;
      end
      e.eg = eg;
      e.xg = xg;
      e.av = av;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare every sampled cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("entry_gate", {4'd0, entry_gate}, {4'd0, e.eg});
        check("exit_gate", {4'd0, exit_gate}, {4'd0, e.xg});
        check("available_spaces", available_spaces, e.av);
        check("parking_full", {4'd0, parking_full}, {4'd0, (e.av == 5'd0)});
        check("parking_empty", {4'd0, parking_empty}, {4'd0, (e.av == 5'd2)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    // reset state
    run(0, 0, 0, 2, 0, 0, 5'd2);
    // held-high entry: one request only
    run(0, 1, 0, 1, 1, 0, 5'd1);
    run(0, 1, 0, 7, 1, 0, 5'd1);
    run(0, 1, 0, 2, 0, 0, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    // second entry fills the lot
    run(0, 1, 0, 1, 1, 0, 5'd0);
    run(0, 0, 0, 7, 1, 0, 5'd0);
    run(0, 0, 0, 1, 0, 0, 5'd0);
    // entry while full is dropped
    run(0, 1, 0, 1, 0, 0, 5'd0);
    run(0, 0, 0, 9, 0, 0, 5'd0);
    // exit then a following entry
    run(0, 0, 1, 1, 0, 1, 5'd1);
    run(0, 0, 0, 7, 0, 1, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    run(0, 1, 0, 1, 1, 0, 5'd0);
    run(0, 0, 0, 7, 1, 0, 5'd0);
    run(0, 0, 0, 1, 0, 0, 5'd0);
    // simultaneous at full: exit only
    run(0, 1, 1, 1, 0, 1, 5'd1);
    run(0, 0, 0, 7, 0, 1, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    // simultaneous at occupied=1: both open, count unchanged
    run(0, 1, 1, 1, 1, 1, 5'd1);
    run(0, 0, 0, 7, 1, 1, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    // exit to empty, then exit at empty is dropped
    run(0, 0, 1, 1, 0, 1, 5'd2);
    run(0, 0, 0, 7, 0, 1, 5'd2);
    run(0, 0, 0, 1, 0, 0, 5'd2);
    run(0, 0, 1, 1, 0, 0, 5'd2);
    run(0, 0, 0, 2, 0, 0, 5'd2);
    // simultaneous at empty: entry only
    run(0, 1, 1, 1, 1, 0, 5'd1);
    run(0, 0, 0, 7, 1, 0, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    // fill, then exit with a second exit edge while the gate is open (ignored)
    run(0, 1, 0, 1, 1, 0, 5'd0);
    run(0, 0, 0, 7, 1, 0, 5'd0);
    run(0, 0, 0, 1, 0, 0, 5'd0);
    run(0, 0, 1, 1, 0, 1, 5'd1);
    run(0, 0, 0, 1, 0, 1, 5'd1);
    run(0, 0, 1, 1, 0, 1, 5'd1);
    run(0, 0, 0, 5, 0, 1, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    // reset while entry gate open, between clock edges
    run(0, 1, 0, 1, 1, 0, 5'd0);
    run(0, 0, 0, 2, 1, 0, 5'd0);
    run(1, 0, 0, 1, 0, 0, 5'd2);
    run(0, 0, 0, 3, 0, 0, 5'd2);
    // single-cycle entry pulse after reset
    run(0, 1, 0, 1, 1, 0, 5'd1);
    run(0, 0, 0, 7, 1, 0, 5'd1);
    run(0, 0, 0, 1, 0, 0, 5'd1);
    repeat (3) @(posedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
